// File: rtl/cache_pkg.sv
// Shared types and address helpers for the data-cache miss/write handler.
// The statistics counters are built only when CACHE_STATS_EN is defined.
package cache_pkg;

    // Word offset inside a byte address; data words are 4 bytes.
    localparam int OFFSET_W = 2;

    // Default geometry, matching the top-level parameter defaults.
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_SET_COUNT = 8;
    localparam int DEF_SW        = $clog2(DEF_SET_COUNT);
    localparam int DEF_TW        = DEF_ADDR_W - DEF_SW - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FILL  = 2'd2,
        WRITE = 2'd3
    } cache_ctrl_state_t;

    // Set index of a byte address. The address is passed zero-extended to
    // 64 bits so one helper serves every ADDRESS_WIDTH / set-width pair.
    function automatic logic [63:0] addr_set(input logic [63:0] addr, input int sw);
        logic [63:0] mask;
        mask = (64'd1 << sw) - 64'd1;
        return (addr >> OFFSET_W) & mask;
    endfunction

    // Tag of a byte address: everything above the set index.
    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int sw);
        return addr >> (OFFSET_W + sw);
    endfunction

endpackage

// File: rtl/cache_stats.sv
// Hit/miss statistics counters for the miss handler.
// Instantiated by cache_miss_ctrl only when CACHE_STATS_EN is defined.
module cache_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_hit,
    input  logic        count_miss,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    // Free-running counters; they wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (count_hit)
                hit_cnt <= hit_cnt + 32'd1;
            if (count_miss)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss/write handler between a direct-mapped data cache and data memory.
// Loads that miss are fetched from memory and written back into the cache
// through the fill port; every store is written through to memory and, if it
// hit, also updates the cache (no-write-allocate on store misses).
// Optional feature: define CACHE_STATS_EN to build the hit/miss counters;
// otherwise hit_cnt and miss_cnt are tied to zero.
module cache_miss_ctrl
    import cache_pkg::*;
#(
    parameter  int DATA_WIDTH    = 32,
    parameter  int ADDRESS_WIDTH = 32,
    parameter  int SET_WIDTH     = 8,
    localparam int SW            = $clog2(SET_WIDTH),
    localparam int TW            = ADDRESS_WIDTH - SW - OFFSET_W
) (
    input  logic                     clk,
    input  logic                     rst,
    // pipeline request, qualified by the cache lookup result
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic                     hit,
    output logic                     stall,
    // data memory port
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    // cache fill port
    output logic                     fill_en,
    output logic [SW-1:0]            fill_set,
    output logic [TW-1:0]            fill_tag,
    output logic [DATA_WIDTH-1:0]    fill_data,
    // statistics
    output logic [31:0]              hit_cnt,
    output logic [31:0]              miss_cnt
);

    cache_ctrl_state_t state;
    logic              store_hit;   // latched hit flag of the store in flight
    logic              fill_en_q;   // fill strobe for a completed load miss

    // A request needs the handler when it is a store or a load that missed.
    logic needs_service;
    assign needs_service = req_valid & (req_we | ~hit);

    // Main controller: latches the request in IDLE and sequences the memory
    // transaction and the cache fill; all memory/fill fields are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            store_hit <= 1'b0;
            fill_en_q <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            fill_set  <= '0;
            fill_tag  <= '0;
            fill_data <= '0;
        end else begin
            // NOTE: every sequential assignment is non-blocking so all
            // registers update from the same pre-edge values; the strobe is
            // cleared by default and raised only in the cycle that needs it.
            fill_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (needs_service) begin
                        mem_req  <= 1'b1;
                        mem_we   <= req_we;
                        mem_addr <= {req_addr[ADDRESS_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        fill_set <= SW'(addr_set(64'(req_addr), SW));
                        fill_tag <= TW'(addr_tag(64'(req_addr), SW));
                        if (req_we) begin
                            // Store data goes to memory and, on a hit, to the cache.
                            mem_wdata <= req_wdata;
                            fill_data <= req_wdata;
                            store_hit <= hit;
                            state     <= WRITE;
                        end else begin
                            store_hit <= 1'b0;
                            state     <= READ;
                        end
                    end
                end

                READ: begin
                    // Address stays stable until memory acknowledges.
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        fill_data <= mem_rdata;
                        fill_en_q <= 1'b1;
                        state     <= FILL;
                    end
                end

                FILL: begin
                    // The fill strobe is visible this cycle; the pipeline then
                    // replays the load, which hits.
                    state <= IDLE;
                end

                WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: a store hit must update the cache in the very cycle memory
    // acknowledges it, so that strobe is the one combinational term here;
    // reset suppresses it because an abandoned store must not fill.
    assign fill_en = fill_en_q | ((state == WRITE) & mem_ack & store_hit & ~rst);

    // Freeze the pipeline while busy, or immediately when a new request needs
    // service; never while reset is asserted.
    assign stall = ~rst & ((state != IDLE) | needs_service);

`ifdef CACHE_STATS_EN
    // Requests are only counted when actually sampled, i.e. in IDLE.
    logic count_hit;
    logic count_miss;
    assign count_hit  = (state == IDLE) & req_valid &  hit;
    assign count_miss = (state == IDLE) & req_valid & ~hit;

    cache_stats u_stats (
        .clk        (clk),
        .rst        (rst),
        .count_hit  (count_hit),
        .count_miss (count_miss),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );
`else
    assign hit_cnt  = 32'd0;
    assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl. A driver issues requests and
// plays the memory; expected memory transactions and cache fills go into
// queues that an independent monitor drains as the DUT presents them.
module tb_cache_miss_ctrl;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int SETS = 8;
    localparam int SW   = 3;
    localparam int TW   = 27;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_we, hit;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          stall;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          fill_en;
    logic [SW-1:0] fill_set;
    logic [TW-1:0] fill_tag;
    logic [DW-1:0] fill_data;
    logic [31:0]   hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    cache_miss_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .SET_WIDTH     (SETS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .hit       (hit),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .fill_en   (fill_en),
        .fill_set  (fill_set),
        .fill_tag  (fill_tag),
        .fill_data (fill_data),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [SW-1:0] set;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        logic          with_ack;   // store hit: fill coincides with memory ack
    } fill_exp_t;

    mem_exp_t  mem_q[$];
    fill_exp_t fill_q[$];
    logic [DW-1:0] mem_model [logic [AW-1:0]];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] set_of(input logic [AW-1:0] a);
        return SW'((a >> 2) % SETS);
    endfunction

    function automatic logic [TW-1:0] tag_of(input logic [AW-1:0] a);
        return TW'(a >> 5);
    endfunction

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        mem_exp_t  e;
        fill_exp_t f;
        if (mem_req) begin
            if (mem_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_mem_req: got addr 0x%0h, expected no request", mem_addr);
            end else begin
                check("mem_addr", 64'(mem_addr), 64'(mem_q[0].addr));
                if (mem_ack) begin
                    e = mem_q.pop_front();
                    check("mem_we", 64'(mem_we), 64'(e.we));
                    if (e.we)
                        check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                end
            end
        end
        if (fill_en) begin
            if (fill_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_fill: got set %0d data 0x%0h, expected no fill", fill_set, fill_data);
            end else begin
                f = fill_q.pop_front();
                check("fill_set",    64'(fill_set),           64'(f.set));
                check("fill_tag",    64'(fill_tag),           64'(f.tag));
                check("fill_data",   64'(fill_data),          64'(f.data));
                check("fill_timing", 64'(mem_req && mem_ack), 64'(f.with_ack));
            end
        end
    end

    task automatic check_counters(input string tag);
`ifdef CACHE_STATS_EN
        check({tag, "_hit_cnt"},  64'(hit_cnt),  64'(exp_hits));
        check({tag, "_miss_cnt"}, 64'(miss_cnt), 64'(exp_misses));
`else
        check({tag, "_hit_cnt"},  64'(hit_cnt),  64'd0);
        check({tag, "_miss_cnt"}, 64'(miss_cnt), 64'd0);
`endif
    endtask

    // Issue one request at the start of a cycle and play the memory with
    // 'lat' cycles of mem_req before the ack. Returns one cycle after stall drops.
    task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic hit_in, input int lat);
        logic [AW-1:0] waddr;
        logic [DW-1:0] rdata;
        int exp_stall, n_stall, seen, cyc;
        bit acked;
        waddr = {addr[AW-1:2], 2'b00};
        rdata = '0;
        if (hit_in) exp_hits++; else exp_misses++;
        if (we) begin
            exp_stall = lat + 1;
            mem_q.push_back('{we: 1'b1, addr: waddr, wdata: wdata});
            mem_model[waddr] = wdata;
            if (hit_in)
                fill_q.push_back('{set: set_of(addr), tag: tag_of(addr), data: wdata, with_ack: 1'b1});
        end else if (!hit_in) begin
            exp_stall = lat + 2;
            rdata = mem_model.exists(waddr) ? mem_model[waddr] : $urandom;
            mem_model[waddr] = rdata;
            mem_q.push_back('{we: 1'b0, addr: waddr, wdata: '0});
            fill_q.push_back('{set: set_of(addr), tag: tag_of(addr), data: rdata, with_ack: 1'b0});
        end else begin
            exp_stall = 0;
        end

        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; hit = hit_in;
        n_stall = 0; seen = 0; cyc = 0; acked = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n_stall++;
            if (cyc > 100) begin
                n_checks++;
                n_fail++;
                $display("FAIL txn_timeout: got %0d stall cycles, expected %0d", n_stall, exp_stall);
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (acked) begin
                req_valid = 1'b0;
            end else begin
                // Pipeline inputs wander while stalled; the DUT must ignore them.
                req_valid = 1'($urandom); req_we = 1'($urandom); hit = 1'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
                if (mem_req) begin
                    seen++;
                    if (seen == lat) begin
                        mem_ack = 1'b1;
                        if (!we) mem_rdata = rdata;
                        acked = 1;
                    end
                end
            end
        end
        check("stall_cycles", 64'(n_stall), 64'(exp_stall));
        @(posedge clk);
        #1;
        req_valid = 1'b0; mem_ack = 1'b0;
        check_counters("txn");
    endtask

    // Load miss followed by the pipeline's replay, which hits.
    task automatic load_miss(input logic [AW-1:0] addr, input int lat);
        do_txn(1'b0, addr, '0, 1'b0, lat);
        do_txn(1'b0, addr, '0, 1'b1, 0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; hit = 1'b0; req_addr = 32'h100; req_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // Reset state; stall forced low even with a pending miss on the inputs.
        check("rst_stall",     64'(stall),     64'd0);
        check("rst_mem_req",   64'(mem_req),   64'd0);
        check("rst_mem_we",    64'(mem_we),    64'd0);
        check("rst_mem_addr",  64'(mem_addr),  64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_fill_en",   64'(fill_en),   64'd0);
        check("rst_fill_set",  64'(fill_set),  64'd0);
        check("rst_fill_tag",  64'(fill_tag),  64'd0);
        check("rst_fill_data", 64'(fill_data), 64'd0);
        check_counters("rst");
        @(posedge clk);
        #1;
        rst = 1'b0; req_valid = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases.
        mem_model[32'h1004] = 32'hDEADBEEF;
        do_txn(1'b0, 32'h40, '0, 1'b1, 0);              // load hit
        load_miss(32'h1004, 2);                         // load miss, 4-cycle stall
        do_txn(1'b1, 32'h20, 32'h55, 1'b0, 1);          // store miss
        do_txn(1'b1, 32'h24, 32'hA5, 1'b1, 2);          // store hit
        load_miss(32'h7, 1);                            // minimum 3-cycle stall, low bits ignored

        // Reset in READ together with the ack: no fill, counters cleared.
        exp_misses++;
        mem_q.push_back('{we: 1'b0, addr: 32'h2000, wdata: '0});
        req_valid = 1'b1; req_we = 1'b0; hit = 1'b0; req_addr = 32'h2000;
        @(posedge clk);
        #1;
        check("pre_rst_mem_req", 64'(mem_req), 64'd1);
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h12345678;
        req_valid = 1'b1; hit = 1'b0;
        @(negedge clk);
        check("rst_mid_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; mem_ack = 1'b0; req_valid = 1'b0;
        exp_hits = 0; exp_misses = 0;
        @(negedge clk);
        check("post_rst_mem_req", 64'(mem_req), 64'd0);
        check("post_rst_fill_en", 64'(fill_en), 64'd0);
        check("post_rst_stall",   64'(stall),   64'd0);
        check_counters("post_rst");
        @(posedge clk);
        #1;

        // Randomised mix over a small address pool so loads see earlier stores.
        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            int lat;
            a = {22'd0, 8'($urandom_range(0, 63)), 2'($urandom)};
            lat = $urandom_range(1, 4);
            case ($urandom_range(0, 3))
                0:       do_txn(1'b0, a, '0, 1'b1, 0);
                1:       load_miss(a, lat);
                default: do_txn(1'b1, a, $urandom, 1'($urandom), lat);
            endcase
        end

        repeat (3) @(posedge clk);
        check("mem_q_drained",  64'(mem_q.size()),  64'd0);
        check("fill_q_drained", 64'(fill_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
